// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-address generator.
//   pc_state_e      : RUN (sequential fetch), DELAY (fetching the branch delay
//                     slot, target pending), HALTED (fetch stopped until reset).
//   PC_RESET_VECTOR : default boot address (MIPS kseg1 boot ROM).
//   PC_HALT_ADDR    : default address whose redirect halts fetch.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_DELAY  = 2'd1,
    PC_HALTED = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_if.sv
// Bus between decode/branch resolution and the program-counter unit.
//   stall, redirect, target : control from the pipeline (master side)
//   addr, addr_link         : fetch address and link return address
//   active, in_delay_slot   : fetch status
//   fault, err_nested       : sticky error flags
// The master modport belongs to the pipeline, the slave modport to pc_unit.
// WIDTH must match the WIDTH parameter of the attached pc_unit.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] addr_link;
  logic             active;
  logic             in_delay_slot;
  logic             fault;
  logic             err_nested;

  modport master (
    output stall, redirect, target,
    input  addr, addr_link, active, in_delay_slot, fault, err_nested
  );

  modport slave (
    input  stall, redirect, target,
    output addr, addr_link, active, in_delay_slot, fault, err_nested
  );

endinterface

// File: rtl/pc_unit.sv
// Parametrised fetch-address generator with a one-instruction branch delay
// slot, stall, halt-on-redirect-to-HALT_ADDR and misaligned-target fault.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : pc_unit_if slave (stall/redirect/target in; addr, addr_link,
//           active, in_delay_slot, fault, err_nested out)
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter int unsigned INCR         = 4,
  parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR,
  parameter int unsigned ALIGN_BITS   = 2
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] RV      = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] HALT    = WIDTH'(HALT_ADDR);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] LINK    = WIDTH'(2 * INCR);
  // Mask form keeps ALIGN_BITS=0 legal (no alignment requirement).
  localparam logic [WIDTH-1:0] AL_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             fault_q, fault_d;
  logic             err_nested_q, err_nested_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PC_RUN;
      addr_q       <= RV;
      pending_q    <= '0;
      fault_q      <= 1'b0;
      err_nested_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      fault_q      <= fault_d;
      err_nested_q <= err_nested_d;
    end
  end

  // Next-state logic; everything holds while stalled or halted.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pending_d    = pending_q;
    fault_d      = fault_q;
    err_nested_d = err_nested_q;
    if (!bus.stall) begin
      unique case (state_q)
        PC_RUN: begin
          addr_d = addr_q + STEP;
          if (bus.redirect) begin
            pending_d = bus.target;
            state_d   = PC_DELAY;
          end
        end
        PC_DELAY: begin
          addr_d = pending_q;
          if (bus.redirect) err_nested_d = 1'b1;
          if ((pending_q & AL_MASK) != '0) begin
            fault_d = 1'b1;
            state_d = PC_HALTED;
          end else if (pending_q == HALT) begin
            state_d = PC_HALTED;
          end else begin
            state_d = PC_RUN;
          end
        end
        PC_HALTED: ;
        default: state_d = PC_HALTED;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.addr          = addr_q;
    bus.addr_link     = addr_q + LINK;
    bus.active        = (state_q != PC_HALTED);
    bus.in_delay_slot = (state_q == PC_DELAY);
    bus.fault         = fault_q;
    bus.err_nested    = err_nested_q;
  end

endmodule
